tx_fifo_arbiter: RTL
====================

# tx_fifo_arbiter

Packet-level round-robin arbiter that shares one UART TX byte FIFO (the SIMPLE_FIFO instance in front of the UART transmitter) between two byte-stream requesters, e.g. debug-module response and status/ack generator. A grant locks the FIFO write port to one requester until that requester's LAST byte has been written, so packets never interleave on the wire. A watchdog releases the lock if the owning requester stalls mid-packet and reports the abort.

## Interface
- DBITS, 8: byte width, equal to the TX FIFO data width.
- TIMEOUT, 255: requester-stall cycles tolerated mid-packet before forced release; 0 disables the watchdog.
- CW, derived = $clog2(TIMEOUT+1) (minimum 1): watchdog counter width; not to be overridden.

- CLK_I  in  1  single clock, all state on rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- VALID_I  in  2  per-requester byte valid; bit i belongs to requester i.
- DATA0_I / DATA1_I  in  DBITS each  requester byte.
- LAST_I  in  2  bit i marks requester i's current byte as end of packet.
- READY_O  out  2  per-requester accept; a byte moves when VALID_I[i] & READY_O[i].
- FIFO_FULL_I  in  1  FULL_O of TX FIFO.
- FIFO_WE_O  out  1  TX FIFO write enable.
- FIFO_WDATA_O  out  DBITS  TX FIFO write data.
- BUSY_O  out  1  a requester owns the FIFO.
- OWNER_O  out  1  index of current owner (valid while BUSY_O).
- ABORT_O  out  1  one-cycle pulse: watchdog released a lock.
- ABORT_ID_O  out  1  requester aborted; held until next abort.

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, priority pointer PRIO (1 bit), watchdog counter WDOG (CW bits), ABORT_O, ABORT_ID_O.
- IDLE: READY_O = 0. If exactly one VALID_I bit set, next state OWN of that requester. Both set: next state OWN_PRIO. None: stay.
- OWNi: READY_O[i] = ~FIFO_FULL_I, other bit 0. FIFO_WE_O = VALID_I[i] & READY_O[i]; FIFO_WDATA_O = DATAi_I (combinational mux, no register). Non-owner inputs are ignored and never written.
- Transfer with LAST_I[i]=1: next state IDLE, PRIO <= ~i, WDOG <= 0.
- Transfer without LAST: stay, WDOG <= 0.
- No transfer because FIFO_FULL_I=1: stay, WDOG holds (FIFO backpressure never counts).
- No transfer because VALID_I[i]=0 and FIFO not full: WDOG <= WDOG+1. When WDOG == TIMEOUT-1 on such a cycle (TIMEOUT>0): next state IDLE, ABORT_O <= 1, ABORT_ID_O <= i, PRIO <= ~i, WDOG <= 0. Bytes already written stay in the FIFO.
- Transfer and expiry cannot coincide: expiry only advances on non-transfer cycles.
- WDOG saturates by construction (reset at expiry); no wrap.
- FIFO_WE_O is never asserted when FIFO_FULL_I=1; FIFO writes are never dropped.
- Reset values: state IDLE, PRIO 0, WDOG 0, READY_O 0, FIFO_WE_O 0, FIFO_WDATA_O 0 (mux selects 0 in IDLE), BUSY_O 0, OWNER_O 0, ABORT_O 0, ABORT_ID_O 0.
- Reset mid-packet: lock dropped immediately, no ABORT_O pulse, partial packet left in FIFO.

## Timing
- Arbitration latency: VALID_I seen in IDLE at cycle N; READY_O earliest at N+1; first byte written at N+1.
- Within a packet: one byte per cycle when VALID high and FIFO not full.
- After LAST transfer at cycle M: IDLE at M+1 (one mandatory bubble), next grant effective M+2.
- BUSY_O/OWNER_O are registered state decodes; ABORT_O registered, high exactly one cycle (the first IDLE cycle after release).
- READY_O, FIFO_WE_O, FIFO_WDATA_O are combinational from state, VALID_I, DATA, FIFO_FULL_I; no path from READY_O to VALID_I is required.

## Test plan
- Single packet: after reset, requester 0 sends 0xA1,0xA2,0xA3(LAST), FIFO empty -> grant at cycle 1, FIFO_WE_O high cycles 1-3 with those bytes, BUSY_O low at cycle 4, PRIO=1.
- Contention: both VALID from reset, req0 3-byte packet, req1 2-byte packet 0xB1,0xB2 -> req0 bytes written first, no interleave, then bubble, req1 bytes; second round with both valid grants req0 again only after req1 finished (alternation).
- Backpressure: FIFO_FULL_I high for 300 cycles mid-packet, TIMEOUT=255 -> READY_O low, no write, no ABORT_O; packet completes after FULL clears.
- Watchdog: req1 granted, sends 1 byte, then drops VALID with FIFO not full -> ABORT_O pulse exactly 255 cycles later, ABORT_ID_O=1, state IDLE, waiting req0 granted next cycle.
- TIMEOUT=0: owner stalls 1000 cycles -> no abort, lock held.
- Reset mid-packet: RST_I high for 1 cycle during req0 byte 2 -> next cycle BUSY_O=0, READY_O=0, ABORT_O=0, PRIO=0.

Source files
------------

// File: rtl/tx_fifo_arbiter.sv
// Packet-level round-robin arbiter that shares one UART TX FIFO write port between two
// byte-stream requesters. A stall watchdog force-releases a lock held by a stuck requester.
module tx_fifo_arbiter #(
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [1:0]       VALID_I,
    input  logic [DBITS-1:0] DATA0_I,
    input  logic [DBITS-1:0] DATA1_I,
    input  logic [1:0]       LAST_I,
    output logic [1:0]       READY_O,
    input  logic             FIFO_FULL_I,
    output logic             FIFO_WE_O,
    output logic [DBITS-1:0] FIFO_WDATA_O,
    output logic             BUSY_O,
    output logic             OWNER_O,
    output logic             ABORT_O,
    output logic             ABORT_ID_O
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WDOG_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          abort_q, abort_d;
    logic          abort_id_q, abort_id_d;

    logic busy, owner, own_valid, own_last, xfer, stall, expire;

    // The unused encoding decodes as idle and falls back to ST_IDLE below.
    assign busy      = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign owner     = (state_q == ST_OWN1);
    assign own_valid = owner ? VALID_I[1] : VALID_I[0];
    assign own_last  = owner ? LAST_I[1] : LAST_I[0];
    assign xfer      = busy && own_valid && !FIFO_FULL_I;
    assign stall     = busy && !own_valid && !FIFO_FULL_I;
    assign expire    = (TIMEOUT > 0) && stall && (wdog_q == WDOG_LAST);

    assign READY_O   = {busy && owner && !FIFO_FULL_I, busy && !owner && !FIFO_FULL_I};
    assign FIFO_WE_O = xfer;
    assign BUSY_O    = busy;
    assign OWNER_O   = owner;
    assign ABORT_O   = abort_q;
    assign ABORT_ID_O = abort_id_q;

    always_comb begin
        FIFO_WDATA_O = '0;
        case (state_q)
            ST_OWN0: FIFO_WDATA_O = DATA0_I;
            ST_OWN1: FIFO_WDATA_O = DATA1_I;
            default: FIFO_WDATA_O = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        prio_d     = prio_q;
        wdog_d     = wdog_q;
        abort_d    = 1'b0;
        abort_id_d = abort_id_q;
        case (state_q)
            ST_IDLE: begin
                case (VALID_I)
                    2'b01:   state_d = ST_OWN0;
                    2'b10:   state_d = ST_OWN1;
                    2'b11:   state_d = prio_q ? ST_OWN1 : ST_OWN0;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                if (xfer) begin
                    wdog_d = '0;
                    if (own_last) begin
                        state_d = ST_IDLE;
                        prio_d  = ~owner;
                    end
                end else if (expire) begin
                    state_d    = ST_IDLE;
                    abort_d    = 1'b1;
                    abort_id_d = owner;
                    prio_d     = ~owner;
                    wdog_d     = '0;
                end else if (stall && (TIMEOUT > 0)) begin
                    // FIFO backpressure never reaches here, so only requester stalls count.
                    wdog_d = wdog_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            wdog_q     <= '0;
            abort_q    <= 1'b0;
            abort_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            wdog_q     <= wdog_d;
            abort_q    <= abort_d;
            abort_id_q <= abort_id_d;
        end
    end
endmodule
